// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared state type and default constants for the tick monitor
package clk_mon_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;
   localparam int SYS_CLK_HZ  = 50000000;
   localparam int DEFAULT_TOL = 2;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: synchronizes an async level into clk and emits registered rise/fall pulses
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_rise_now,
   output logic o_rise_pulse,
   output logic o_fall_pulse
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   w_s;
   logic                   w_fall;
   assign w_s        = r_sync[SYNC_STAGES-1];
   assign o_rise_now = w_s & ~r_prev;
   assign w_fall     = ~w_s & r_prev;
   // shift the input through the synchronizer, keep the previous level and register the edge pulses
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync       <= '0;
         r_prev       <= 1'b0;
         o_rise_pulse <= 1'b0;
         o_fall_pulse <= 1'b0;
      end else begin
         r_sync       <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev       <= w_s;
         o_rise_pulse <= o_rise_now;
         o_fall_pulse <= w_fall;
      end
   end
endmodule

// File: rtl/clk_tick_monitor.sv
// clk_tick_monitor: edge enables, rise-to-rise period measurement and lock/timeout tracking of a slow clock
module clk_tick_monitor
   import clk_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 32,
   parameter int MAX_PERIOD  = 50000000,
   parameter int LOCK_COUNT  = 4,
   parameter int TOL         = DEFAULT_TOL
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_slow_in,
   output logic             o_rise_pulse,
   output logic             o_fall_pulse,
   output logic [CNT_W-1:0] o_period_out,
   output logic             o_period_valid,
   output logic             o_locked,
   output logic             o_timeout
);
   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_PERIOD);
   localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(MAX_PERIOD - 1);
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_ref;
   logic             r_ref_valid;
   logic [MW-1:0]    r_match;
   logic             w_rise;
   logic [CNT_W-1:0] w_meas;
   logic [CNT_W:0]   w_meas_x;
   logic [CNT_W:0]   w_ref_x;
   logic [CNT_W:0]   w_diff;
   logic             w_in_tol;
   logic [MW-1:0]    w_match_inc;
   logic             w_tmo;
   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_async      (i_slow_in),
      .o_rise_now   (w_rise),
      .o_rise_pulse (o_rise_pulse),
      .o_fall_pulse (o_fall_pulse)
   );
   // measured period and its absolute distance from the reference, via compare-then-subtract
   always_comb begin
      w_meas      = r_cnt + CNT_W'(1);
      w_meas_x    = {1'b0, w_meas};
      w_ref_x     = {1'b0, r_ref};
      w_diff      = (w_meas_x >= w_ref_x) ? w_meas_x - w_ref_x : w_ref_x - w_meas_x;
      w_in_tol    = w_diff <= (CNT_W+1)'(TOL);
      w_match_inc = r_match + MW'(1);
      w_tmo       = (r_cnt == LP_LAST) && !w_rise;
   end
   // period counter, acquire/lock state machine and registered status outputs
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_ref          <= '0;
         r_ref_valid    <= 1'b0;
         r_match        <= '0;
         o_period_out   <= '0;
         o_period_valid <= 1'b0;
         o_locked       <= 1'b0;
         o_timeout      <= 1'b0;
      end else begin
         o_period_valid <= 1'b0;
         o_timeout      <= 1'b0;
         r_cnt          <= w_rise ? '0 : (r_cnt == LP_MAX) ? r_cnt : r_cnt + CNT_W'(1);
         if (w_rise) begin
            if (r_state != ST_IDLE) begin
               o_period_out   <= w_meas;
               o_period_valid <= 1'b1;
            end
            case (r_state)
               ST_IDLE: begin
                  r_state     <= ST_ACQUIRE;
                  r_ref_valid <= 1'b0;
                  r_match     <= '0;
               end
               ST_ACQUIRE: begin
                  if (!r_ref_valid) begin
                     r_ref       <= w_meas;
                     r_ref_valid <= 1'b1;
                     r_match     <= '0;
                  end else if (w_in_tol) begin
                     r_match <= w_match_inc;
                     if (w_match_inc == MW'(LOCK_COUNT)) begin
                        r_state  <= ST_LOCKED;
                        o_locked <= 1'b1;
                     end
                  end else begin
                     r_ref   <= w_meas;
                     r_match <= '0;
                  end
               end
               ST_LOCKED: begin
                  if (!w_in_tol) begin
                     r_state     <= ST_ACQUIRE;
                     r_ref       <= w_meas;
                     r_ref_valid <= 1'b1;
                     r_match     <= '0;
                     o_locked    <= 1'b0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (w_tmo) begin
            o_timeout   <= 1'b1;
            r_state     <= ST_IDLE;
            o_locked    <= 1'b0;
            r_ref_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_clk_tick_monitor.sv
// tb_clk_tick_monitor: directed checks of edge latency, period measurement, lock, timeout and reset
module tb_clk_tick_monitor;
   localparam int CNT_W = 16;
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             slow_in = 1'b0;
   logic             rise_pulse, fall_pulse, period_valid, locked, timeout;
   logic [CNT_W-1:0] period_out;
   int               checks = 0;
   int               errors = 0;
   int               cyc = 0;
   int               last_rise_cyc = 0;
   int               n_tmo = 0;

   clk_tick_monitor #(
      .SYNC_STAGES(2), .CNT_W(CNT_W), .MAX_PERIOD(64), .LOCK_COUNT(3), .TOL(1)
   ) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_slow_in      (slow_in),
      .o_rise_pulse   (rise_pulse),
      .o_fall_pulse   (fall_pulse),
      .o_period_out   (period_out),
      .o_period_valid (period_valid),
      .o_locked       (locked),
      .o_timeout      (timeout)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (rise_pulse) last_rise_cyc = cyc;
      if (timeout) n_tmo++;
   endtask

   // one slow_in period of hi+lo cycles; checks the outputs seen at its rise pulse
   task automatic period(input string tag, input int hi, input int lo,
                         input bit exp_pv, input int exp_per, input bit exp_lock);
      int n_rise = 0;
      int n_fall = 0;
      slow_in = 1'b1;
      for (int i = 0; i < hi + lo; i++) begin
         if (i == hi) slow_in = 1'b0;
         step();
         if (fall_pulse) n_fall++;
         if (rise_pulse) begin
            n_rise++;
            chk({tag, "_pv"}, int'(period_valid), int'(exp_pv));
            if (exp_pv) chk({tag, "_per"}, int'(period_out), exp_per);
            chk({tag, "_lock"}, int'(locked), int'(exp_lock));
         end
      end
      chk({tag, "_nrise"}, n_rise, 1);
      chk({tag, "_nfall"}, n_fall, 1);
   endtask

   initial begin
      bit got;
      for (int i = 0; i < 5; i++) begin
         slow_in = (i % 2 == 1);
         step();
         chk("rst_outs", int'({rise_pulse, fall_pulse, period_valid, locked, timeout}), 0);
         chk("rst_per", int'(period_out), 0);
      end
      slow_in = 1'b0;
      reset = 1'b0;
      repeat (3) step();
      slow_in = 1'b1;
      step();
      step();
      chk("lat_early", int'(rise_pulse), 0);
      step();
      chk("lat_rise", int'(rise_pulse), 1);
      chk("idle_pv", int'(period_valid), 0);
      repeat (2) step();
      slow_in = 1'b0;
      repeat (5) step();
      period("p2", 5, 5, 1, 10, 0);
      period("p3", 5, 5, 1, 10, 0);
      period("p4", 5, 5, 1, 10, 0);
      period("p5", 5, 5, 1, 10, 1);
      period("p6", 5, 5, 1, 10, 1);
      period("p7", 6, 5, 1, 10, 1);
      period("p8", 6, 7, 1, 11, 1);
      period("p9", 6, 7, 1, 13, 0);
      period("p10", 6, 7, 1, 13, 0);
      period("p11", 6, 7, 1, 13, 0);
      period("p12", 6, 7, 1, 13, 1);
      chk("no_tmo_yet", n_tmo, 0);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         step();
         if (timeout) begin
            got = 1'b1;
            chk("tmo_dist", cyc - last_rise_cyc, 64);
            chk("tmo_lock", int'(locked), 0);
         end
      end
      chk("tmo_seen", int'(got), 1);
      repeat (20) step();
      chk("tmo_once", n_tmo, 1);
      period("b1", 32, 32, 0, 0, 0);
      period("b2", 32, 32, 1, 64, 0);
      chk("bnd_no_tmo", n_tmo, 1);
      period("l1", 5, 5, 1, 64, 0);
      period("l2", 5, 5, 1, 10, 0);
      period("l3", 5, 5, 1, 10, 0);
      period("l4", 5, 5, 1, 10, 0);
      period("l5", 5, 5, 1, 10, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mrst_lock", int'(locked), 0);
      chk("mrst_per", int'(period_out), 0);
      period("r1", 5, 5, 0, 0, 0);
      period("r2", 5, 5, 1, 10, 0);
      period("r3", 5, 5, 1, 10, 0);
      period("r4", 5, 5, 1, 10, 0);
      period("r5", 5, 5, 1, 10, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
